// File: rtl/rram_pkg.sv
// Shared constants for the RRAM access controller: address field layout and FSM encoding.
package rram_pkg;

   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned BLK_W   = 2;
   localparam int unsigned ROW_W   = 5;
   localparam int unsigned COL_W   = 5;
   localparam int unsigned BLK_LSB = 10;
   localparam int unsigned ROW_LSB = 5;
   localparam int unsigned COL_LSB = 0;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LATCH = 3'd1;
   localparam logic [2:0] SETUP = 3'd2;
   localparam logic [2:0] BURST = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

endpackage

// File: rtl/rram_burst_counter.sv
// Remaining-length down-counter and current-address incrementer for one burst.
module rram_burst_counter #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned LEN_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              cnt_en_i,
   input  logic              addr_en_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   logic [LEN_W:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
      if (load_i) begin
         // A zero length field encodes the full 2^LEN_W burst.
         cnt_d  = (len_i == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_i};
         addr_d = start_addr_i;
      end else begin
         if (cnt_en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - (LEN_W + 1)'(1);
         end
         if (addr_en_i) begin
            addr_d = addr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         addr_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (cnt_q == (LEN_W + 1)'(1));

endmodule

// File: rtl/rram_access_ctrl.sv
// Host-request sequencer that drives the RRAM decoder's ALE / parallel address / count enable.
module rram_access_ctrl #(
   parameter int unsigned ADDR_W = rram_pkg::ADDR_W,
   parameter int unsigned LEN_W  = rram_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              abort,
   output logic              ale,
   output logic [ADDR_W-1:0] dec_din,
   output logic              dec_en,
   output logic              dec_we,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   import rram_pkg::*;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic              aborted_q, aborted_d;
   logic              accept;
   logic              in_burst;
   logic              last;
   logic              addr_step;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid & req_ready;
   assign in_burst  = (state_q == BURST);
   // Freeze the address on the final or aborted cycle so DONE shows the last selected address.
   assign addr_step = in_burst & ~abort & ~last;

   always_comb begin
      state_d   = state_q;
      aborted_d = in_burst & abort & ~last;
      case (state_q)
         IDLE:    if (accept) state_d = LATCH;
         LATCH:   state_d = SETUP;
         SETUP:   state_d = BURST;
         BURST:   if (last || abort) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         aborted_q <= aborted_d;
         if (accept) begin
            addr_q  <= req_addr;
            write_q <= req_write;
         end
      end
   end

   rram_burst_counter #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_burst_counter (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .load_i       (accept),
      .start_addr_i (req_addr),
      .len_i        (req_len),
      .cnt_en_i     (in_burst),
      .addr_en_i    (addr_step),
      .addr_o       (cur_addr),
      .last_o       (last)
   );

   assign ale     = (state_q == LATCH);
   assign dec_din = addr_q;
   assign dec_en  = in_burst;
   assign dec_we  = in_burst & write_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign aborted = aborted_q;

endmodule

// File: doc/rram_access_ctrl.md
Name: rram_access_ctrl

Overview:
Upstream sequencer for the RRAM address decoder. It accepts one host access request (start address, burst length, read/write), then drives the decoder's address-latch strobe, parallel address and count enable with the decoder's required timing. It holds enable for exactly the requested number of cycles and mirrors the address the decoder is currently selecting. It sits between the host command interface and the block/row/column decoder.

Parameters:
ADDR_W, 12, decoder address width; block = [11:10], row = [9:5], column = [4:0]
LEN_W, 8, burst length field width; 0 encodes 2^LEN_W
BLK_W, 2, block field width
ROW_W, 5, row field width
COL_W, 5, column field width

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write burst, 0 = read burst
req_addr  in  ADDR_W  burst start address
req_len  in  LEN_W  number of addresses in burst (0 means 256)
abort  in  1  terminate active burst
ale  out  1  decoder address-latch strobe
dec_din  out  ADDR_W  parallel address to decoder
dec_en  out  1  decoder count enable
dec_we  out  1  write qualifier to array drivers, valid while dec_en=1
cur_addr  out  ADDR_W  address the decoder selects this cycle
busy  out  1  request in progress
done  out  1  one-cycle completion pulse
aborted  out  1  qualifies done; set when burst ended by abort

Behaviour:
- Reset (rst_n=0 at a clk edge) applies in any state, including mid-burst:
  - state=IDLE
  - ale=0, dec_en=0, dec_we=0, dec_din=0, cur_addr=0, busy=0, done=0, aborted=0
  - req_ready=1 from the first edge after rst_n=1
- FSM states: IDLE, LATCH, SETUP, BURST, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture req_addr, req_write and req_len into registers, then go to LATCH.
  - A request is accepted only when req_valid=1 and req_ready=1.
- LATCH (1 cycle):
  - ale=1, dec_din=captured address, req_ready=0, busy=1.
- SETUP (1 cycle):
  - ale=0; dec_din stays held.
  - Gives the decoder one ALE-low cycle before enable.
- BURST:
  - dec_en=1, dec_we=captured write bit.
  - Cycle 0: cur_addr = start address. Each later cycle, cur_addr increments modulo 2^ADDR_W (0xFFF wraps to 0x000).
  - A remaining-count register is loaded with len (0 → 256) and decrements each BURST cycle.
  - Leave after exactly len cycles: count == 1 → next state DONE.
- DONE (1 cycle):
  - dec_en=0, dec_we=0, done=1, busy=1.
  - Next state IDLE.
  - dec_din and cur_addr hold their last values until the next LATCH.
- Latency: request accept edge → ale high next cycle; first dec_en cycle is 2 cycles after ale.
- Total busy cycles = len + 3.
- abort:
  - Sampled only in BURST. abort=1 → dec_en=0 on the next cycle, state → DONE, with done=1 and aborted=1 that cycle.
  - abort during LATCH or SETUP is ignored.
  - abort in the same cycle as the final count: the burst counts as complete and aborted=0.
- req_valid while busy is not accepted; the host must hold it (no queueing).
- Back-to-back: a request in the IDLE cycle immediately after DONE is accepted, so there is no dead cycle beyond DONE.

Decomposition:
- Shared package `rram_pkg` holds:
  - ADDR_W and the field widths and offsets (BLK_LSB=10, ROW_LSB=5, COL_LSB=0)
  - state encoding constants: IDLE=3'd0, LATCH=1, SETUP=2, BURST=3, DONE=4
- One natural sub-module, `rram_burst_counter`:
  - loadable down-counter (LEN_W+1 bits) plus address incrementer
  - load / enable / last outputs
- The FSM stays in the top module.

Test Plan:
1. Reset mid-burst: rst_n=0 during BURST cycle 3 → next edge dec_en=0, busy=0, cur_addr=0; req_ready=1 after release.
2. Basic read: req_addr=12'h002, len=4, write=0 → ale high 1 cycle with dec_din=0x002; then dec_en high 4 cycles with cur_addr 0x002..0x005 and dec_we=0; then done=1, aborted=0.
3. Wrap and len=0:
   - addr=0xFFE, len=3, write=1 → cur_addr 0xFFE, 0xFFF, 0x000, with dec_we=1.
   - len=0 → exactly 256 dec_en cycles.
4. Abort:
   - abort=1 on BURST cycle 2 of len=10 → dec_en low next cycle, done=1 and aborted=1.
   - abort on the last cycle → aborted=0.
   - abort during SETUP → ignored; full 10 cycles run.
5. Handshake and back-to-back:
   - req_valid held during a burst → not accepted until IDLE.
   - Two requests with req_valid held high → second ale rises exactly one cycle after first done; busy total = len+3 each.
